cordic_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one iterative CORDIC sin/cos engine between NUM_REQ requesters.
- Each requester has its own valid/ready request channel carrying a 16-bit angle, and its own valid/ready response channel returning {sin,cos}.
- The scheduler latches a request, holds the angle stable for the whole computation, and pulses the engine start.
- It waits for the engine's done pulse, or a timeout, then routes the result back to the granted requester.
- It sits between MMIO/accelerator front-ends and the single CORDIC instance.

---
 rtl/cordic_sched_pkg.sv | 18 +
 rtl/cordic_rr_scheduler_if.sv | 53 +++++
 rtl/cordic_rr_scheduler_rr_pick.sv | 31 +++
 rtl/cordic_rr_scheduler.sv | 113 +++++++++++
 tb/tb_cordic_rr_scheduler.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cordic_sched_pkg.sv
// Shared types and defaults for the CORDIC
// round-robin scheduler slice.
package cordic_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_THETA_W = 16;
  localparam int DEF_TIMEOUT = 64;
  localparam int DEF_CNT_W   = $clog2(DEF_TIMEOUT);
  localparam int DEF_ID_W    = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/cordic_rr_scheduler_if.sv
// Requester channels plus engine link of the
// shared CORDIC scheduler.
interface cordic_rr_scheduler_if
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int THETA_W = DEF_THETA_W
);

  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ-1:0]         req_ready;
  logic [NUM_REQ*THETA_W-1:0] req_theta;
  logic [NUM_REQ-1:0]         resp_valid;
  logic [NUM_REQ-1:0]         resp_ready;
  logic [2*THETA_W-1:0]       resp_data;
  logic                       resp_err;
  logic                       core_start;
  logic [THETA_W-1:0]         core_theta;
  logic                       core_done;
  logic [THETA_W-1:0]         core_sin;
  logic [THETA_W-1:0]         core_cos;

  modport master (
    output req_valid,
    output req_theta,
    output resp_ready,
    output core_done,
    output core_sin,
    output core_cos,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  resp_err,
    input  core_start,
    input  core_theta
  );

  modport slave (
    input  req_valid,
    input  req_theta,
    input  resp_ready,
    input  core_done,
    input  core_sin,
    input  core_cos,
    output req_ready,
    output resp_valid,
    output resp_data,
    output resp_err,
    output core_start,
    output core_theta
  );

endinterface

// File: rtl/cordic_rr_scheduler_rr_pick.sv
// Combinational round-robin selector: first set
// request strictly after ptr, with wrap-around.
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int k;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int off = 1; off <= N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one iterative CORDIC engine between
// NUM_REQ requesters, one job in flight.
module cordic_rr_scheduler
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int THETA_W = DEF_THETA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                       clock,
  input  logic                       reset,
  cordic_rr_scheduler_if.slave       bus,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t state;
  state_t state_n;

  logic [THETA_W-1:0]   theta_q;
  logic [ID_W-1:0]      gid_q;
  logic [ID_W-1:0]      ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2*THETA_W-1:0] data_q;
  logic                 err_q;

  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               req_fire;
  logic               resp_fire;
  logic               tmo;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (ptr_q),
    .grant (pick_oh),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign req_fire  = (state == IDLE) && pick_any;
  assign resp_fire = (state == RESP)
                  && bus.resp_ready[gid_q];
  assign tmo       = cnt_q == CNT_W'(TIMEOUT - 1);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (req_fire) state_n = ISSUE;
      ISSUE: state_n = WAIT;
      WAIT:  if (bus.core_done || tmo)
               state_n = RESP;
      RESP:  if (resp_fire) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      theta_q <= '0;
      gid_q   <= '0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_fire) begin
        theta_q <= bus.req_theta[
          int'(pick_idx)*THETA_W +: THETA_W];
        gid_q   <= pick_idx;
      end
      if (state == ISSUE) cnt_q <= '0;
      // done outranks a coincident timeout
      if (state == WAIT) begin
        if (bus.core_done) begin
          data_q <= {bus.core_sin, bus.core_cos};
          err_q  <= 1'b0;
        end else if (tmo) begin
          data_q <= '0;
          err_q  <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
      if (resp_fire) ptr_q <= gid_q;
    end
  end

  assign bus.req_ready  = (state == IDLE)
                        ? pick_oh : '0;
  assign bus.core_start = state == ISSUE;
  assign bus.core_theta = theta_q;
  assign bus.resp_valid = (state == RESP)
                        ? (NUM_REQ'(1) << gid_q)
                        : '0;
  assign bus.resp_data  = data_q;
  assign bus.resp_err   = err_q;
  assign busy           = state != IDLE;
  assign grant_id       = gid_q;

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler with a stub
// engine: done N cycles after start.
module tb_cordic_rr_scheduler;

  localparam int N  = 4;
  localparam int TW = 16;
  localparam int TO = 64;

  logic       clock = 1'b0;
  logic       reset;
  logic       busy;
  logic [1:0] grant_id;

  cordic_rr_scheduler_if #(
    .NUM_REQ (N),
    .THETA_W (TW)
  ) bus ();

  cordic_rr_scheduler #(
    .NUM_REQ (N),
    .THETA_W (TW),
    .TIMEOUT (TO)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clock = ~clock;

  logic          stub_done = 1'b0;
  logic          stray;
  logic [TW-1:0] stub_th = '0;
  int            stub_cnt = 0;
  int            stub_n;
  bit            stub_en;

  always @(posedge clock) begin
    stub_done <= 1'b0;
    if (reset) begin
      stub_cnt <= 0;
    end else if (bus.core_start) begin
      stub_th  <= bus.core_theta;
      stub_cnt <= stub_en ? stub_n - 1 : 0;
      if (stub_en && stub_n == 1)
        stub_done <= 1'b1;
    end else if (stub_cnt > 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) stub_done <= 1'b1;
    end
  end

  assign bus.core_done = stub_done | stray;
  assign bus.core_sin  = stub_th;
  assign bus.core_cos  = ~stub_th;

  int checks   = 0;
  int failures = 0;

  task automatic chk(string nm,
                     logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_hs(input int bound,
                         output int id,
                         output int waited);
    id = -1;
    waited = 0;
    for (int c = 0; c < bound; c++) begin
      #1;
      if ((bus.req_valid & bus.req_ready) != 0) begin
        for (int i = 0; i < N; i++)
          if (bus.req_ready[i]) id = i;
        waited = c;
        return;
      end
      tick();
    end
    checks++;
    failures++;
    $display("FAIL req_handshake actual=none required=within_%0d",
             bound);
  endtask

  task automatic wait_resp(input int bound);
    for (int c = 0; c < bound; c++) begin
      if (bus.resp_valid != 0) return;
      tick();
    end
    checks++;
    failures++;
    $display("FAIL resp_wait actual=none required=within_%0d",
             bound);
  endtask

  typedef struct {
    int          id;
    logic [15:0] th;
    int          dly;
    bit          en;
    logic [31:0] exp_data;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v);
    int id;
    int w;
    int lat;
    bit held;
    stub_en = v.en;
    stub_n  = v.dly;
    bus.req_theta[v.id*TW +: TW] = v.th;
    bus.req_valid[v.id] = 1'b1;
    wait_hs(10, id, w);
    chk("grant_sel", id, v.id);
    tick();
    bus.req_valid[v.id] = 1'b0;
    chk("start_pulse", bus.core_start, 1);
    chk("issue_theta", bus.core_theta, v.th);
    chk("grant_id_out", grant_id, v.id);
    lat  = 0;
    held = 1'b1;
    while (bus.resp_valid == 0 && lat < 200) begin
      tick();
      lat++;
      if (bus.core_theta !== v.th) held = 1'b0;
      if (bus.core_start !== 1'b0) held = 1'b0;
    end
    chk("resp_latency", lat, v.exp_lat);
    chk("theta_held", held, 1);
    chk("resp_valid_bit", bus.resp_valid, 1 << v.id);
    chk("resp_data", bus.resp_data, v.exp_data);
    chk("resp_err", bus.resp_err, v.exp_err);
    bus.resp_ready[v.id] = 1'b1;
    tick();
    bus.resp_ready[v.id] = 1'b0;
    chk("idle_after_resp", busy, 0);
  endtask

  function automatic int model_pick(int ptr,
                                    logic [N-1:0] v);
    for (int off = 1; off <= N; off++)
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    return -1;
  endfunction

  vec_t tbl[5];

  initial begin
    int id;
    int w;
    int ptr_m;
    bit busy_m;
    int cur_id;
    logic [TW-1:0] cur_th;
    logic [TW-1:0] th;
    logic [N-1:0] pend;
    logic [N-1:0] er;
    int started;
    int finished;
    int k;
    bit ok;

    tbl[0] = '{0, 16'h2000, 14, 1, 32'h2000DFFF, 0, 15};
    tbl[1] = '{3, 16'hFFFF,  1, 1, 32'hFFFF0000, 0,  2};
    tbl[2] = '{1, 16'h0F0F, 14, 0, 32'h00000000, 1, 65};
    tbl[3] = '{2, 16'h1234, 64, 1, 32'h1234EDCB, 0, 65};
    tbl[4] = '{2, 16'h8001, 63, 1, 32'h80017FFE, 0, 64};

    reset          = 1'b1;
    stray          = 1'b0;
    stub_en        = 1'b1;
    stub_n         = 14;
    bus.req_valid  = '0;
    bus.req_theta  = '0;
    bus.resp_ready = '0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_core_start", bus.core_start, 0);
    chk("rst_core_theta", bus.core_theta, 0);
    chk("rst_resp_data", bus.resp_data, 0);
    chk("rst_resp_err", bus.resp_err, 0);
    chk("rst_grant_id", grant_id, 0);
    reset = 1'b0;

    // continuous requests from everyone
    for (int i = 0; i < N; i++)
      bus.req_theta[i*TW +: TW] = TW'((i + 1) * 16'h1000);
    bus.req_valid  = '1;
    bus.resp_ready = '1;
    for (int j = 0; j < 5; j++) begin
      wait_hs(10, id, w);
      chk("rr_order", id, j % N);
      if (j > 0) chk("rr_back_to_back", w, 0);
      tick();
      wait_resp(40);
      th = TW'(((j % N) + 1) * 16'h1000);
      chk("rr_resp_bit", bus.resp_valid, 1 << (j % N));
      chk("rr_resp_data", bus.resp_data, {th, ~th});
      if (j == 4) bus.req_valid = '0;
      tick();
    end
    bus.resp_ready = '0;

    foreach (tbl[i]) run_vec(tbl[i]);

    // response backpressure while req2 waits
    stub_en = 1'b1;
    stub_n  = 14;
    bus.req_theta[1*TW +: TW] = 16'h1111;
    bus.req_valid[1] = 1'b1;
    wait_hs(10, id, w);
    chk("bp_grant1", id, 1);
    tick();
    bus.req_valid[1] = 1'b0;
    bus.req_theta[2*TW +: TW] = 16'h2222;
    bus.req_valid[2] = 1'b1;
    wait_resp(40);
    bus.resp_ready = 4'b1101;
    for (int c = 0; c < 10; c++) begin
      #1;
      chk("bp_resp_valid", bus.resp_valid, 4'b0010);
      chk("bp_resp_data", bus.resp_data, 32'h1111EEEE);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_busy", busy, 1);
      tick();
    end
    bus.resp_ready = 4'b0010;
    tick();
    bus.resp_ready = '0;
    #1;
    chk("bp_next_grant", bus.req_ready, 4'b0100);
    wait_hs(10, id, w);
    chk("bp_grant2", id, 2);
    tick();
    bus.req_valid[2] = 1'b0;
    wait_resp(40);
    chk("bp_resp2_data", bus.resp_data, 32'h2222DDDD);
    bus.resp_ready[2] = 1'b1;
    tick();
    bus.resp_ready[2] = 1'b0;

    // reset mid-WAIT, then a stray done
    run_vec('{0, 16'h0ABC, 5, 1, 32'h0ABCF543, 0, 6});
    stub_n = 14;
    bus.req_theta[1*TW +: TW] = 16'h5555;
    bus.req_valid[1] = 1'b1;
    wait_hs(10, id, w);
    tick();
    bus.req_valid[1] = 1'b0;
    repeat (3) tick();
    chk("mid_wait_busy", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_grant_id", grant_id, 0);
    stray = 1'b1;
    tick();
    stray = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (busy !== 1'b0 || bus.resp_valid !== '0)
        ok = 1'b0;
      tick();
    end
    chk("dropped_job_silent", ok, 1);
    bus.req_theta[0*TW +: TW] = 16'h7777;
    bus.req_theta[3*TW +: TW] = 16'h3333;
    bus.req_valid = 4'b1001;
    #1;
    chk("post_rst_first_pick", bus.req_ready, 4'b0001);
    wait_hs(10, id, w);
    tick();
    bus.req_valid = '0;
    wait_resp(40);
    chk("post_rst_resp_bit", bus.resp_valid, 4'b0001);
    chk("post_rst_resp_data", bus.resp_data, 32'h77778888);
    bus.resp_ready = '1;
    tick();
    bus.resp_ready = '0;

    // randomized traffic vs queue-free model
    ptr_m    = 0;
    busy_m   = 1'b0;
    cur_id   = 0;
    cur_th   = '0;
    pend     = '0;
    started  = 0;
    finished = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      if (cyc >= 3000 && pend == 0 && !busy_m) break;
      stub_n = $urandom_range(1, 30);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && cyc < 3000
            && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          bus.req_theta[i*TW +: TW] = TW'($urandom);
        end
      end
      bus.req_valid  = pend;
      bus.resp_ready = (cyc < 3000)
                     ? N'($urandom) : '1;
      #1;
      chk("rnd_busy", busy, busy_m);
      er = '0;
      k  = model_pick(ptr_m, pend);
      if (!busy_m && k >= 0) er[k] = 1'b1;
      chk("rnd_req_ready", bus.req_ready, er);
      if (bus.resp_valid != 0) begin
        chk("rnd_resp_bit", bus.resp_valid, 1 << cur_id);
        chk("rnd_resp_data", bus.resp_data,
            {cur_th, ~cur_th});
        chk("rnd_resp_err", bus.resp_err, 0);
        if (bus.resp_ready[cur_id]) begin
          busy_m = 1'b0;
          ptr_m  = cur_id;
          finished++;
        end
      end else if (!busy_m && k >= 0) begin
        busy_m  = 1'b1;
        cur_id  = k;
        cur_th  = bus.req_theta[k*TW +: TW];
        pend[k] = 1'b0;
        started++;
      end
      tick();
    end
    chk("rnd_jobs_done", finished, started);
    chk("rnd_drained", {pend, busy_m}, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
